// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-stage PC generator for the RV32I pipeline.
// Holds pc_f, chooses the next fetch address (redirect > stall > BTB > +4),
// owns the IF/ID PC fields and a direct-mapped BTB of 2-bit counters.
// Optional build macro PC_FETCH_MISALIGN_TRAP_EN: adds output misalign_e and
// makes pc_f hold, rather than redirect, when the redirect address is misaligned.
module pc_fetch_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               BTB_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             stall_d,
  input  logic             flush_d,
  input  logic             redirect_e,
  input  logic [WIDTH-1:0] redirect_pc_e,
  input  logic             upd_valid_e,
  input  logic [WIDTH-1:0] upd_pc_e,
  input  logic [WIDTH-1:0] upd_target_e,
  input  logic             upd_taken_e,
  output logic [WIDTH-1:0] pc_f,
  output logic [WIDTH-1:0] pc_plus4_f,
  output logic             pred_taken_f,
  output logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] pc_plus4_d,
  output logic             pred_taken_d,
`ifdef PC_FETCH_MISALIGN_TRAP_EN
  output logic             misalign_e,
`endif
  output logic             valid_d
);
  localparam int IDX  = $clog2(BTB_DEPTH);
  localparam int TAGW = WIDTH - IDX - 2;

  // BTB storage: only the valid bits are reset; an invalid entry never hits.
  logic [BTB_DEPTH-1:0] btb_vld;
  logic [TAGW-1:0]      btb_tag [BTB_DEPTH];
  logic [WIDTH-1:0]     btb_tgt [BTB_DEPTH];
  logic [1:0]           btb_ctr [BTB_DEPTH];

  logic [IDX-1:0]   idx_f, idx_u;
  logic [TAGW-1:0]  tag_f, tag_u;
  logic             hit_f, hit_u;
  logic [WIDTH-1:0] redir_pc;
  logic             take_redir, hold_f;
  logic [1:0]       ctr_u_nxt;

  // Instruction addresses are word aligned; the update PC low bits carry nothing.
  logic unused_upd_lo;
  assign unused_upd_lo = ^upd_pc_e[1:0];

  assign idx_f        = pc_f[IDX+1:2];
  assign tag_f        = pc_f[WIDTH-1:IDX+2];
  assign idx_u        = upd_pc_e[IDX+1:2];
  assign tag_u        = upd_pc_e[WIDTH-1:IDX+2];
  assign pc_plus4_f   = pc_f + WIDTH'(4);
  assign hit_f        = btb_vld[idx_f] && (btb_tag[idx_f] == tag_f);
  assign hit_u        = btb_vld[idx_u] && (btb_tag[idx_u] == tag_u);
  assign pred_taken_f = hit_f && btb_ctr[idx_f][1];
  assign redir_pc     = {redirect_pc_e[WIDTH-1:2], 2'b00};

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  // A misaligned redirect is reported to the trap logic; fetch parks in place.
  assign misalign_e = redirect_e && (redirect_pc_e[1:0] != 2'b00);
  assign take_redir = redirect_e && !misalign_e;
  assign hold_f     = stall_f || misalign_e;
`else
  logic unused_redir_lo;
  assign unused_redir_lo = ^redirect_pc_e[1:0];
  assign take_redir      = redirect_e;
  assign hold_f          = stall_f;
`endif

  // Next fetch PC: redirect wins over stall, then BTB prediction, then +4.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               pc_f <= RESET_PC;
    else if (take_redir)   pc_f <= redir_pc;
    else if (hold_f)       pc_f <= pc_f;
    else if (pred_taken_f) pc_f <= btb_tgt[idx_f];
    else                   pc_f <= pc_plus4_f;
  end

  // IF/ID register: a redirect squashes the fetched instruction like a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_d         <= '0;
      pc_plus4_d   <= '0;
      pred_taken_d <= 1'b0;
      valid_d      <= 1'b0;
    end else if (flush_d || redirect_e) begin
      pred_taken_d <= 1'b0;
      valid_d      <= 1'b0;
    end else if (!stall_d) begin
      pc_d         <= pc_f;
      pc_plus4_d   <= pc_plus4_f;
      pred_taken_d <= pred_taken_f;
      valid_d      <= 1'b1;
    end
  end

  // Saturating 2-bit counter step for the entry being updated.
  always_comb begin
    ctr_u_nxt = btb_ctr[idx_u];
    if (upd_taken_e) begin
      if (btb_ctr[idx_u] != 2'd3) ctr_u_nxt = btb_ctr[idx_u] + 2'd1;
    end else begin
      if (btb_ctr[idx_u] != 2'd0) ctr_u_nxt = btb_ctr[idx_u] - 2'd1;
    end
  end

  // BTB valid bits: set on a taken miss (allocation); cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        btb_vld <= '0;
    else if (upd_valid_e && !hit_u && upd_taken_e)  btb_vld[idx_u] <= 1'b1;
  end

  // BTB payload: train on hit, allocate weakly-taken on a taken miss.
  // Lookup reads the pre-update contents in the same cycle.
  always_ff @(posedge clk) begin
    if (upd_valid_e) begin
      if (hit_u) begin
        btb_ctr[idx_u] <= ctr_u_nxt;
        if (upd_taken_e) btb_tgt[idx_u] <= upd_target_e;
      end else if (upd_taken_e) begin
        btb_tag[idx_u] <= tag_u;
        btb_tgt[idx_u] <= upd_target_e;
        btb_ctr[idx_u] <= 2'b10;
      end
    end
  end

endmodule
